genius_display_ctrl: RTL and testbench
======================================

GENIUS_DISPLAY_CTRL -- requirements
Module: genius_display_ctrl

Interface
REQ-001 SHALL have parameter H_DISP, default 640, visible width in pixels.
REQ-002 SHALL have parameter V_DISP, default 480, visible height in lines.
REQ-003 SHALL have parameter GAP_FRAMES, default 6, dark frames after each lit period; legal range 1..255.
REQ-004 SHALL have port px_clk  input  1  pixel clock; sole clock.
REQ-005 SHALL have port rst_n  input  1  reset; synchronous, active-low.
REQ-006 SHALL have port x_px  input  10  current pixel column from the sync generator.
REQ-007 SHALL have port y_px  input  10  current pixel line from the sync generator.
REQ-008 SHALL have port activevideo  input  1  high inside the visible area.
REQ-009 SHALL have port vsync  input  1  vertical sync, active-low.
REQ-010 SHALL have port cmd_valid  input  1  light command offered.
REQ-011 SHALL have port cmd_color  input  2  quadrant to light: 0 green TL, 1 red TR, 2 yellow BL, 3 blue BR.
REQ-012 SHALL have port cmd_frames  input  8  lit duration in frames.
REQ-013 SHALL have port clear  input  1  synchronous abort of the current command.
REQ-014 SHALL have port cmd_ready  output  1  command accepted when high with cmd_valid.
REQ-015 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-016 SHALL have port done  output  1  one-cycle pulse at command completion.
REQ-017 SHALL have ports red, green, blue  output  4 each  pixel colour.

Function
REQ-018 SHALL derive frame_tick as the vsync falling edge: vsync_d==1 and vsync==0, where vsync_d is vsync registered one px_clk.
REQ-019 SHALL implement FSM states IDLE, ARM, LIT and GAP.
REQ-020 IDLE: cmd_ready=1; on cmd_valid with cmd_frames!=0, latch colour and count, go to ARM.
REQ-021 IDLE with cmd_valid and cmd_frames==0: accept the command, stay in IDLE, pulse done on the next cycle.
REQ-022 ARM: on frame_tick go to LIT with cnt=latched cmd_frames; no lighting is shown in ARM.
REQ-023 LIT: on frame_tick decrement cnt; on the tick where cnt==1, go to GAP with cnt=GAP_FRAMES.
REQ-024 GAP: on frame_tick decrement cnt; on the tick where cnt==1, go to IDLE and pulse done in the same cycle as the transition.
REQ-025 cmd_ready SHALL be 0 in ARM, LIT and GAP; commands offered then are ignored and not queued.
REQ-026 clear SHALL force IDLE on the next edge from any state, without a done pulse; clear has priority over frame_tick and over command acceptance.
REQ-027 Quadrant index SHALL be {y_px >= V_DISP/2, x_px >= H_DISP/2}, with the y comparison as the MSB.
REQ-028 Lit colours (R,G,B): green 0,F,0; red F,0,0; yellow F,F,0; blue 0,0,F.
REQ-029 Dim colours SHALL be each lit component shifted right by 2 (F becomes 3).
REQ-030 Only the latched quadrant SHALL be lit, and only in LIT; all other quadrants, and all quadrants in IDLE, ARM and GAP, are dim.
REQ-031 RGB SHALL be registered with exactly 1 px_clk latency from x_px, y_px and activevideo, and SHALL be 0 when the registered activevideo is 0.
REQ-032 A state change SHALL affect RGB from the cycle after the transition edge.

Reset
REQ-033 With rst_n low at a px_clk edge: state=IDLE, cnt=0, latched colour=0, vsync_d=1, done=0, and red, green and blue all 0.
REQ-034 After reset: cmd_ready=1 and busy=0 from the first cycle.
REQ-035 rst_n SHALL take priority over clear and over every other input.

Verification
REQ-036 Reset then cmd_valid=1, color=1, frames=3, held 1 cycle -> busy=1 next cycle; TR pixel is F,0,0 only after the next frame_tick; exactly 3 lit frames, then 6 dim frames; done pulses once; busy=0 the cycle after done.
REQ-037 cmd_frames=0 in IDLE -> no ARM; done=1 exactly one cycle later; RGB stays dim.
REQ-038 clear asserted mid-LIT -> IDLE next edge; done never pulses; RGB dim one cycle later; a new command is accepted immediately after.
REQ-039 cmd_valid held high during LIT -> cmd_ready=0 and the command is ignored; after done, cmd_ready=1 and the still-held command is taken.
REQ-040 Pixel sweep x=319/320, y=239/240 with color=3 lit -> only BR region reads 0,0,F; other regions read dim values; activevideo=0 -> 0,0,0, each with 1-cycle latency.
REQ-041 rst_n low during GAP with clear=1 -> all outputs at their reset values next edge; no done pulse.

Source files
------------

// File: rtl/genius_display_ctrl.sv
// Genius (Simon) game display controller: lights one screen quadrant for a
// number of frames, then holds a dark gap before accepting the next command.
module genius_display_ctrl #(
  parameter int H_DISP     = 640,
  parameter int V_DISP     = 480,
  parameter int GAP_FRAMES = 6
) (
  input  logic       px_clk,
  input  logic       rst_n,
  input  logic [9:0] x_px,
  input  logic [9:0] y_px,
  input  logic       activevideo,
  input  logic       vsync,
  input  logic       cmd_valid,
  input  logic [1:0] cmd_color,
  input  logic [7:0] cmd_frames,
  input  logic       clear,
  output logic       cmd_ready,
  output logic       busy,
  output logic       done,
  output logic [3:0] red,
  output logic [3:0] green,
  output logic [3:0] blue
);

  typedef enum logic [1:0] {IDLE, ARM, LIT, GAP} state_t;

  localparam logic [7:0] GAP_CNT = 8'(GAP_FRAMES);
  localparam logic [9:0] HALF_X  = 10'(H_DISP / 2);
  localparam logic [9:0] HALF_Y  = 10'(V_DISP / 2);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [1:0]  color_q, color_d;
  logic        done_q, done_d;
  logic        vsync_q;
  logic        frame_tick;
  logic [1:0]  quad;
  logic [11:0] pix;
  logic [11:0] rgb_q, rgb_d;

  // Quadrant index doubles as the colour index: 0 TL green, 1 TR red, 2 BL yellow, 3 BR blue.
  function automatic logic [11:0] litColor(input logic [1:0] c);
    case (c)
      2'd0:    litColor = 12'h0F0;
      2'd1:    litColor = 12'hF00;
      2'd2:    litColor = 12'hFF0;
      default: litColor = 12'h00F;
    endcase
  endfunction

  assign frame_tick = vsync_q & ~vsync;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    color_d = color_q;
    done_d  = 1'b0;
    if (clear) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            color_d = cmd_color;
            if (cmd_frames == 8'd0) begin
              done_d = 1'b1;
            end else begin
              state_d = ARM;
              cnt_d   = cmd_frames;
            end
          end
        end
        ARM: begin
          if (frame_tick) state_d = LIT;
        end
        LIT: begin
          if (frame_tick) begin
            if (cnt_q == 8'd1) begin
              state_d = GAP;
              cnt_d   = GAP_CNT;
            end else begin
              cnt_d = cnt_q - 8'd1;
            end
          end
        end
        GAP: begin
          if (frame_tick) begin
            if (cnt_q == 8'd1) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
            cnt_d = cnt_q - 8'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Dimmed quadrants keep their hue at a quarter of full intensity.
  always_comb begin
    quad = {(y_px >= HALF_Y), (x_px >= HALF_X)};
    pix  = litColor(quad);
    if (!((state_q == LIT) && (quad == color_q))) begin
      pix = {pix[11:8] >> 2, pix[7:4] >> 2, pix[3:0] >> 2};
    end
    rgb_d = activevideo ? pix : 12'h000;
  end

  always_ff @(posedge px_clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      color_q <= 2'd0;
      done_q  <= 1'b0;
      vsync_q <= 1'b1;
      rgb_q   <= 12'h000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      color_q <= color_d;
      done_q  <= done_d;
      vsync_q <= vsync;
      rgb_q   <= rgb_d;
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign red       = rgb_q[11:8];
  assign green     = rgb_q[7:4];
  assign blue      = rgb_q[3:0];

endmodule

// File: tb/tb_genius_display_ctrl.sv
// Self-checking bench for genius_display_ctrl: directed scenarios, a pixel
// table and randomized traffic, all compared against a frame-level model.
module tb_genius_display_ctrl;

  localparam int H_DISP = 640;
  localparam int V_DISP = 480;
  localparam int GAP_FRAMES = 6;
  localparam int P_IDLE = 0, P_ARM = 1, P_LIT = 2, P_GAP = 3;

  logic       px_clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] x_px = '0, y_px = '0;
  logic       activevideo = 1'b0, vsync = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd_color = '0;
  logic [7:0] cmd_frames = '0;
  logic       clear = 1'b0;
  logic       cmd_ready, busy, done;
  logic [3:0] red, green, blue;

  int nCompared = 0;
  int nFailed = 0;
  int doneCount = 0;

  // Model: phase, frames remaining in that phase, latched colour, last vsync.
  int         mPhase = P_IDLE, mRem = 0, mCol = 0;
  logic       mPrevVs = 1'b1;
  logic       mDone = 1'b0;
  logic [11:0] mRgb = 12'h000;

  genius_display_ctrl #(.H_DISP(H_DISP), .V_DISP(V_DISP), .GAP_FRAMES(GAP_FRAMES)) dut (
    .px_clk(px_clk), .rst_n(rst_n), .x_px(x_px), .y_px(y_px),
    .activevideo(activevideo), .vsync(vsync), .cmd_valid(cmd_valid),
    .cmd_color(cmd_color), .cmd_frames(cmd_frames), .clear(clear),
    .cmd_ready(cmd_ready), .busy(busy), .done(done),
    .red(red), .green(green), .blue(blue)
  );

  always #5 px_clk = ~px_clk;

  function automatic logic [11:0] expectedPixel(int x, int y, bit av, int phase, int col);
    int q;
    logic [3:0] on;
    logic [11:0] hue;
    if (!av) return 12'h000;
    q = ((y >= V_DISP / 2) ? 2 : 0) + ((x >= H_DISP / 2) ? 1 : 0);
    on = (phase == P_LIT && q == col) ? 4'hF : 4'h3;
    case (q)
      0: hue = 12'h010;
      1: hue = 12'h100;
      2: hue = 12'h110;
      default: hue = 12'h001;
    endcase
    return hue * on;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nFailed++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelStep();
    bit tick;
    logic nextDone;
    if (!rst_n) begin
      mPhase = P_IDLE; mRem = 0; mCol = 0; mPrevVs = 1'b1; mDone = 1'b0; mRgb = 12'h000;
      return;
    end
    tick = mPrevVs && !vsync;
    nextDone = 1'b0;
    mRgb = expectedPixel(x_px, y_px, activevideo, mPhase, mCol);
    if (clear) mPhase = P_IDLE;
    else if (mPhase == P_IDLE) begin
      if (cmd_valid) begin
        mCol = cmd_color;
        if (cmd_frames == 0) nextDone = 1'b1;
        else begin mPhase = P_ARM; mRem = cmd_frames; end
      end
    end else if (tick) begin
      if (mPhase == P_ARM) mPhase = P_LIT;
      else if (mRem > 1) mRem--;
      else if (mPhase == P_LIT) begin mPhase = P_GAP; mRem = GAP_FRAMES; end
      else begin mPhase = P_IDLE; nextDone = 1'b1; end
    end
    mPrevVs = vsync;
    mDone = nextDone;
  endtask

  task automatic checkOutput();
    cmp("busy", busy, mPhase != P_IDLE);
    cmp("cmd_ready", cmd_ready, mPhase == P_IDLE);
    cmp("done", done, mDone);
    cmp("rgb", {red, green, blue}, mRgb);
    if (done === 1'b1) doneCount++;
  endtask

  task automatic applyStimulus();
    modelStep();
    @(posedge px_clk);
    #1;
    checkOutput();
  endtask

  task automatic frameTick();
    vsync = 1'b0;
    applyStimulus();
    vsync = 1'b1;
    repeat (4) applyStimulus();
  endtask

  task automatic sendCmd(input logic [1:0] c, input logic [7:0] f);
    cmd_valid = 1'b1; cmd_color = c; cmd_frames = f;
    applyStimulus();
    cmd_valid = 1'b0;
  endtask

  task automatic clearNow();
    clear = 1'b1;
    applyStimulus();
    clear = 1'b0;
  endtask

  task automatic runUntilDone(input int maxCycles, output bit seen);
    seen = 1'b0;
    for (int k = 0; k < maxCycles; k++) begin
      vsync = (k % 5 == 0) ? 1'b0 : 1'b1;
      applyStimulus();
      if (done === 1'b1) begin seen = 1'b1; break; end
    end
    vsync = 1'b1;
  endtask

  typedef struct {
    logic [9:0]  x;
    logic [9:0]  y;
    logic        av;
    logic [11:0] rgb;
  } pixVec_t;

  pixVec_t tbl[10];

  initial begin
    int startDone, litFrames;
    bit seen;

    tbl[0] = '{10'd319, 10'd239, 1'b1, 12'h030};
    tbl[1] = '{10'd320, 10'd239, 1'b1, 12'h300};
    tbl[2] = '{10'd319, 10'd240, 1'b1, 12'h330};
    tbl[3] = '{10'd320, 10'd240, 1'b1, 12'h00F};
    tbl[4] = '{10'd0,   10'd0,   1'b1, 12'h030};
    tbl[5] = '{10'd639, 10'd479, 1'b1, 12'h00F};
    tbl[6] = '{10'd639, 10'd0,   1'b1, 12'h300};
    tbl[7] = '{10'd0,   10'd479, 1'b1, 12'h330};
    tbl[8] = '{10'd320, 10'd240, 1'b0, 12'h000};
    tbl[9] = '{10'd319, 10'd239, 1'b0, 12'h000};

    // Reset and basic lit/gap sequence on the top-right quadrant.
    rst_n = 1'b0;
    repeat (2) applyStimulus();
    cmp("reset_rgb", {red, green, blue}, 12'h000);
    rst_n = 1'b1;
    applyStimulus();
    cmp("post_reset_ready", cmd_ready, 1'b1);
    cmp("post_reset_busy", busy, 1'b0);
    x_px = 10'd320; y_px = 10'd10; activevideo = 1'b1;
    sendCmd(2'd1, 8'd3);
    cmp("accept_busy", busy, 1'b1);
    applyStimulus();
    cmp("arm_dim", {red, green, blue}, 12'h300);
    startDone = doneCount;
    litFrames = 0;
    for (int f = 0; f < 10; f++) begin
      frameTick();
      if ({red, green, blue} === 12'hF00) litFrames++;
    end
    cmp("lit_frames", litFrames, 3);
    cmp("done_pulses", doneCount - startDone, 1);
    cmp("idle_after_done", busy, 1'b0);

    // Zero-length command completes immediately without lighting.
    sendCmd(2'd1, 8'd0);
    cmp("zero_done", done, 1'b1);
    cmp("zero_busy", busy, 1'b0);
    applyStimulus();
    cmp("zero_done_end", done, 1'b0);
    cmp("zero_dim", {red, green, blue}, 12'h300);

    // Clear in the middle of the lit period.
    sendCmd(2'd1, 8'd4);
    frameTick();
    frameTick();
    cmp("lit_before_clear", {red, green, blue}, 12'hF00);
    startDone = doneCount;
    clearNow();
    cmp("clear_busy", busy, 1'b0);
    applyStimulus();
    cmp("clear_dim", {red, green, blue}, 12'h300);
    sendCmd(2'd2, 8'd2);
    cmp("after_clear_accept", busy, 1'b1);
    cmp("clear_no_done", doneCount - startDone, 0);
    clearNow();

    // Command held during LIT is ignored, then taken once idle.
    sendCmd(2'd0, 8'd1);
    cmd_valid = 1'b1; cmd_color = 2'd2; cmd_frames = 8'd2;
    frameTick();
    cmp("held_ready_lit", cmd_ready, 1'b0);
    runUntilDone(200, seen);
    cmp("held_done_seen", seen, 1'b1);
    cmp("held_ready_idle", cmd_ready, 1'b1);
    applyStimulus();
    cmp("held_taken", busy, 1'b1);
    cmd_valid = 1'b0;
    clearNow();

    // Pixel sweep across quadrant boundaries with blue lit.
    sendCmd(2'd3, 8'd5);
    frameTick();
    for (int i = 0; i < 10; i++) begin
      x_px = tbl[i].x; y_px = tbl[i].y; activevideo = tbl[i].av;
      applyStimulus();
      cmp($sformatf("sweep%0d", i), {red, green, blue}, tbl[i].rgb);
    end
    activevideo = 1'b1;
    clearNow();

    // Reset during GAP together with clear.
    sendCmd(2'd0, 8'd1);
    frameTick();
    frameTick();
    cmp("in_gap_busy", busy, 1'b1);
    startDone = doneCount;
    rst_n = 1'b0; clear = 1'b1;
    applyStimulus();
    cmp("rst_gap_busy", busy, 1'b0);
    cmp("rst_gap_ready", cmd_ready, 1'b1);
    cmp("rst_gap_done", done, 1'b0);
    cmp("rst_gap_rgb", {red, green, blue}, 12'h000);
    rst_n = 1'b1; clear = 1'b0;
    applyStimulus();
    cmp("rst_gap_no_done", doneCount - startDone, 0);

    // Randomized traffic against the model.
    for (int n = 0; n < 2500; n++) begin
      rst_n       = ($urandom_range(0, 199) != 0);
      clear       = ($urandom_range(0, 59) == 0);
      cmd_valid   = ($urandom_range(0, 7) == 0);
      cmd_color   = 2'($urandom_range(0, 3));
      cmd_frames  = 8'($urandom_range(0, 3));
      vsync       = ($urandom_range(0, 3) != 0);
      x_px        = 10'($urandom_range(300, 340));
      y_px        = 10'($urandom_range(220, 260));
      activevideo = ($urandom_range(0, 99) < 85);
      applyStimulus();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFailed);
    $finish;
  end

endmodule
